// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one 16x16 unsigned multiplier between NUM_REQ
// valid/ready requesters, with a single ID-tagged valid/ready response channel.

// Combinational 16x16 unsigned multiplier built from three partial-product zones:
// low byte x low byte, the two cross terms, and high byte x high byte.
module three_zone_16bit_multiplier (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    logic [15:0] zone_lo;
    logic [16:0] zone_mid;
    logic [15:0] zone_hi;

    // Partial products and final alignment into the 32-bit result
    always_comb begin
        zone_lo  = 16'(a[7:0]) * 16'(b[7:0]);
        zone_mid = 17'(a[7:0]) * 17'(b[15:8]) + 17'(a[15:8]) * 17'(b[7:0]);
        zone_hi  = 16'(a[15:8]) * 16'(b[15:8]);
        p        = {zone_hi, zone_lo} + (32'(zone_mid) << 8);
    end

endmodule

module mult_share_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    resp_valid,
    output logic [31:0]             resp_p,
    output logic [ID_W-1:0]         resp_id,
    input  logic                    resp_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        op_count
);

    localparam int unsigned OP_W  = 16;
    localparam int unsigned P_W   = 32;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [P_W-1:0]    mult_p;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   last_grant;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    int unsigned       cand;
    logic [OP_W-1:0]   sel_a;
    logic [OP_W-1:0]   sel_b;

    // Single shared multiplier, fed only from the latched operand registers
    three_zone_16bit_multiplier u_mult (
        .a (op_a),
        .b (op_b),
        .p (mult_p)
    );

    // Round-robin search starting one past the last granted requester
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_grant) + k) % NUM_REQ;
            if (!grant_found && req_valid[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Operand mux for the current winner
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_a[i*OP_W +: OP_W];
                sel_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the combinational accept strobe
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready  = NUM_REQ'(1) << grant_idx;
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Nothing is accepted while reset is held
        if (!rst_n) begin
            req_ready = '0;
        end
    end

    // Operand latch, grant pointer, result capture, status and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            owner      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            resp_p     <= '0;
            resp_id    <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            resp_valid <= (state_next == RESP);
            busy       <= (state_next != IDLE);
            if (state == IDLE && grant_found) begin
                op_a       <= sel_a;
                op_b       <= sel_b;
                owner      <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == CALC) begin
                resp_p  <= mult_p;
                resp_id <= owner;
            end
            if (state == RESP && resp_ready) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: table of single operations plus
// contention, backpressure, counter wrap and mid-operation reset sequences.
module tb_mult_share_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 3;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic [31:0]           resp_p;
    logic [ID_W-1:0]       resp_id;
    logic                  resp_ready;
    logic                  busy;
    logic [15:0]           op_count;

    // Narrow-counter copy, driven identically, to observe counter wrap
    logic [NUM_REQ-1:0]    req_ready_s;
    logic                  resp_valid_s;
    logic [31:0]           resp_p_s;
    logic [ID_W-1:0]       resp_id_s;
    logic                  busy_s;
    logic [2:0]            op_count_s;

    int n_vec;
    int n_err;
    int exp_count;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[7];

    mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_p     (resp_p),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .busy       (busy),
        .op_count   (op_count)
    );

    mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(3)) u_dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready_s),
        .resp_valid (resp_valid_s),
        .resp_p     (resp_p_s),
        .resp_id    (resp_id_s),
        .resp_ready (resp_ready),
        .busy       (busy_s),
        .op_count   (op_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts();
        check("op_count", 32'(op_count), 32'(exp_count % 65536));
        check("op_count_wrap3", 32'(op_count_s), 32'(exp_count % 8));
    endtask

    // One isolated request; checks grant, CALC, response latency and count
    task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_p);
        logic [NUM_REQ-1:0] oh;
        oh = NUM_REQ'(1 << id);
        req_valid = oh;
        req_a = '0;
        req_b = '0;
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
        #1;
        check("grant", 32'(req_ready), 32'(oh));
        step();
        req_valid = '0;
        req_a = '1;
        req_b = '1;
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_no_resp", 32'(resp_valid), 32'd0);
        check("calc_no_ready", 32'(req_ready), 32'd0);
        step();
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_p", resp_p, exp_p);
        check("resp_id", 32'(resp_id), 32'(id));
        exp_count++;
        step();
        check("resp_done", 32'(resp_valid), 32'd0);
        check_counts();
    endtask

    // With requests already posted, wait for a grant and expect a specific winner
    task automatic expect_grant_and_resp(input logic [NUM_REQ-1:0] exp_oh, input int exp_id,
                                         input logic [31:0] exp_p);
        int waited;
        waited = 0;
        while (req_ready == '0 && waited < 8) begin
            step();
            waited++;
        end
        if (req_ready == '0) begin
            check("grant_timeout", 32'd0, 32'd1);
        end else begin
            check("rr_grant", 32'(req_ready), 32'(exp_oh));
            step();
            step();
            check("rr_resp_valid", 32'(resp_valid), 32'd1);
            check("rr_resp_id", 32'(resp_id), 32'(exp_id));
            check("rr_resp_p", resp_p, exp_p);
            exp_count++;
            step();
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_count = 0;

        vecs[0] = '{0, 16'd25,     16'd12,     32'd300};
        vecs[1] = '{1, 16'd32767,  16'd12345,  32'd404508615};
        vecs[2] = '{0, 16'hFFFF,   16'hFFFF,   32'hFFFE0001};
        vecs[3] = '{0, 16'd0,      16'd0,      32'd0};
        vecs[4] = '{1, 16'd1,      16'hFFFF,   32'd65535};
        vecs[5] = '{0, 16'hABCD,   16'h1234,   32'd204951460};
        vecs[6] = '{1, 16'd40000,  16'd3,      32'd120000};

        // Reset held with random inputs: all outputs quiet
        rst_n      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid  = NUM_REQ'($urandom);
            req_a      = $urandom;
            req_b      = $urandom;
            resp_ready = 1'($urandom);
            step();
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_p", resp_p, 32'd0);
        end
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_counts();

        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd0);

        // Table of isolated operations
        foreach (vecs[i]) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Contention: both held valid, grants alternate starting from req0
        req_a = {16'd255, 16'd100};
        req_b = {16'd255, 16'd200};
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) expect_grant_and_resp(2'b01, 0, 32'd20000);
            else            expect_grant_and_resp(2'b10, 1, 32'd65025);
        end
        req_valid = '0;
        check_counts();

        // Backpressure: response held while req1 waits
        resp_ready = 1'b0;
        req_a = {16'd3, 16'd1024};
        req_b = {16'd7, 16'd512};
        req_valid = 2'b11;
        #1;
        check("bp_grant0", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b10;
        step();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_p", resp_p, 32'd524288);
            check("bp_no_ready", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        exp_count++;
        check("bp_released", 32'(resp_valid), 32'd0);
        check("bp_grant1", 32'(req_ready), 32'd2);
        step();
        req_valid = '0;
        step();
        check("bp_resp1_p", resp_p, 32'd21);
        check("bp_resp1_id", 32'(resp_id), 32'd1);
        exp_count++;
        step();
        check_counts();

        // Reset during CALC
        req_a = {16'd0, 16'd7};
        req_b = {16'd0, 16'd9};
        req_valid = 2'b01;
        #1;
        step();
        req_valid = '0;
        check("calc_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        check("rstc_busy", 32'(busy), 32'd0);
        check("rstc_resp_valid", 32'(resp_valid), 32'd0);
        check_counts();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rstc_no_resp", 32'(resp_valid), 32'd0);
        end
        run_op(1, 16'd6, 16'd7, 32'd42);
        req_a = {16'd11, 16'd5};
        req_b = {16'd11, 16'd5};
        req_valid = 2'b11;
        #1;
        expect_grant_and_resp(2'b01, 0, 32'd25);
        req_valid = '0;
        check_counts();

        // Reset during RESP, then pointer must be back at requester 0 first
        resp_ready = 1'b0;
        req_a = {16'd0, 16'd300};
        req_b = {16'd0, 16'd300};
        req_valid = 2'b01;
        #1;
        step();
        req_valid = '0;
        step();
        check("resp_pre_rst", 32'(resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        check("rstr_resp_valid", 32'(resp_valid), 32'd0);
        check("rstr_resp_p", resp_p, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        step();
        check("rstr_no_resp", 32'(resp_valid), 32'd0);
        req_a = {16'd2, 16'd1000};
        req_b = {16'd2, 16'd1000};
        req_valid = 2'b11;
        #1;
        expect_grant_and_resp(2'b01, 0, 32'd1000000);
        expect_grant_and_resp(2'b10, 1, 32'd4);
        req_valid = '0;
        check_counts();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
